// File: rtl/mem_port_arbiter.sv
// Shares the mem_ctrl word port between instruction fetch (rq0) and data access (rq1), one transaction per grant.
// Build option MEM_ARB_FIXED_PRI_EN: requester 0 always wins a tie instead of round-robin.
module mem_port_arbiter #(
  parameter int unsigned ADDR_BITCOUNT = 64,
  parameter int unsigned WORD_SIZE     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               rq0_op,
  input  logic [ADDR_BITCOUNT-1:0] rq0_addr,
  input  logic [WORD_SIZE-1:0]     rq0_wdata,
  output logic                     rq0_grant,
  output logic [WORD_SIZE-1:0]     rq0_rdata,
  output logic                     rq0_done,
  input  logic [1:0]               rq1_op,
  input  logic [ADDR_BITCOUNT-1:0] rq1_addr,
  input  logic [WORD_SIZE-1:0]     rq1_wdata,
  output logic                     rq1_grant,
  output logic [WORD_SIZE-1:0]     rq1_rdata,
  output logic                     rq1_done,
  output logic [1:0]               mem_op,
  output logic [ADDR_BITCOUNT-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_wdata,
  input  logic [WORD_SIZE-1:0]     mem_rdata,
  input  logic                     mem_ready,
  input  logic                     mem_tx_done,
  input  logic                     mem_rd_valid
);

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                   state, state_next;
  logic                     win_id, win_id_next;
  logic                     last_grant, last_grant_next;
  logic [1:0]               hold_op, hold_op_next;
  logic [WORD_SIZE-1:0]     rd_word, rd_word_next;
  logic [WORD_SIZE-1:0]     resp_word;
  logic [ADDR_BITCOUNT-1:0] addr_next;
  logic [WORD_SIZE-1:0]     wdata_next;
  logic [1:0]               mem_op_next;
  logic                     rq0_grant_next, rq1_grant_next;
  logic                     rq0_done_next, rq1_done_next;
  logic [WORD_SIZE-1:0]     rq0_rdata_next, rq1_rdata_next;
  logic                     rq0_valid, rq1_valid, pick1;

  assign rq0_valid = (rq0_op == OP_READ) || (rq0_op == OP_WRITE);
  assign rq1_valid = (rq1_op == OP_READ) || (rq1_op == OP_WRITE);

  // Winner when arbitrating: requester 1 takes it only if alone or it is its turn
`ifdef MEM_ARB_FIXED_PRI_EN
  assign pick1 = rq1_valid && !rq0_valid;
`else
  assign pick1 = rq1_valid && (!rq0_valid || (last_grant == 1'b0));
`endif

  always_comb begin
    state_next      = state;
    win_id_next     = win_id;
    last_grant_next = last_grant;
    hold_op_next    = hold_op;
    rd_word_next    = rd_word;
    addr_next       = mem_address;
    wdata_next      = mem_wdata;
    rq0_rdata_next  = rq0_rdata;
    rq1_rdata_next  = rq1_rdata;
    mem_op_next     = OP_IDLE;
    rq0_done_next   = 1'b0;
    rq1_done_next   = 1'b0;
    resp_word       = '0;
    case (state)
      IDLE: begin
        if (mem_ready && (rq0_valid || rq1_valid)) begin
          state_next   = ISSUE;
          win_id_next  = pick1;
          hold_op_next = pick1 ? rq1_op : rq0_op;
          addr_next    = pick1 ? rq1_addr : rq0_addr;
          wdata_next   = pick1 ? rq1_wdata : rq0_wdata;
          rd_word_next = '0;
          mem_op_next  = hold_op_next;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // A read beat coinciding with completion is still captured
        if (mem_rd_valid) rd_word_next = mem_rdata;
        if (mem_tx_done) begin
          state_next = RESP;
          resp_word  = (hold_op == OP_WRITE) ? '0 : rd_word_next;
          if (win_id) begin
            rq1_done_next  = 1'b1;
            rq1_rdata_next = resp_word;
          end else begin
            rq0_done_next  = 1'b1;
            rq0_rdata_next = resp_word;
          end
        end
      end
      RESP: begin
        state_next      = IDLE;
        last_grant_next = win_id;
      end
      default: state_next = IDLE;
    endcase
    rq0_grant_next = (state_next != IDLE) && !win_id_next;
    rq1_grant_next = (state_next != IDLE) && win_id_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      win_id      <= 1'b0;
      last_grant  <= 1'b1;
      hold_op     <= OP_IDLE;
      rd_word     <= '0;
      mem_op      <= OP_IDLE;
      mem_address <= '0;
      mem_wdata   <= '0;
      rq0_grant   <= 1'b0;
      rq1_grant   <= 1'b0;
      rq0_done    <= 1'b0;
      rq1_done    <= 1'b0;
      rq0_rdata   <= '0;
      rq1_rdata   <= '0;
    end else begin
      state       <= state_next;
      win_id      <= win_id_next;
      last_grant  <= last_grant_next;
      hold_op     <= hold_op_next;
      rd_word     <= rd_word_next;
      mem_op      <= mem_op_next;
      mem_address <= addr_next;
      mem_wdata   <= wdata_next;
      rq0_grant   <= rq0_grant_next;
      rq1_grant   <= rq1_grant_next;
      rq0_done    <= rq0_done_next;
      rq1_done    <= rq1_done_next;
      rq0_rdata   <= rq0_rdata_next;
      rq1_rdata   <= rq1_rdata_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle vector table, hand-built corner sequences, randomized traffic vs a timeline model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic [1:0]    rq0_op, rq1_op;
  logic [AW-1:0] rq0_addr, rq1_addr;
  logic [DW-1:0] rq0_wdata, rq1_wdata;
  logic          rq0_grant, rq1_grant, rq0_done, rq1_done;
  logic [DW-1:0] rq0_rdata, rq1_rdata;
  logic [1:0]    mem_op;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready, mem_tx_done, mem_rd_valid;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_BITCOUNT(AW), .WORD_SIZE(DW)) dut (
    .clk(clk), .rst(rst),
    .rq0_op(rq0_op), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_grant(rq0_grant), .rq0_rdata(rq0_rdata), .rq0_done(rq0_done),
    .rq1_op(rq1_op), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_grant(rq1_grant), .rq1_rdata(rq1_rdata), .rq1_done(rq1_done),
    .mem_op(mem_op), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_tx_done(mem_tx_done),
    .mem_rd_valid(mem_rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    bit            rst;
    logic [1:0]    op0, op1;
    bit            rdy, txd, rdv;
    logic [DW-1:0] rdat;
    logic [1:0]    e_op;
    bit            e_g0, e_g1, e_d0, e_d1;
    logic [DW-1:0] e_r0, e_r1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit r, input logic [1:0] o0, input logic [1:0] o1,
                              input bit rdy, input bit txd, input bit rdv, input logic [DW-1:0] rd,
                              input logic [1:0] eop, input bit g0, input bit g1, input bit d0, input bit d1,
                              input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                              input logic [AW-1:0] ea, input logic [DW-1:0] ew);
    vec_t v;
    v.rst = r; v.op0 = o0; v.op1 = o1; v.rdy = rdy; v.txd = txd; v.rdv = rdv; v.rdat = rd;
    v.e_op = eop; v.e_g0 = g0; v.e_g1 = g1; v.e_d0 = d0; v.e_d1 = d1;
    v.e_r0 = r0; v.e_r1 = r1; v.e_addr = ea; v.e_wd = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until mem_op pulses, bounded so a dead DUT cannot hang the run
  task automatic wait_op(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (mem_op == 2'b00 && n < 12);
  endtask

  task automatic do_reset();
    rst = 1'b1; rq0_op = 2'b00; rq1_op = 2'b00;
    mem_tx_done = 1'b0; mem_rd_valid = 1'b0; mem_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  localparam logic [AW-1:0] A0 = 64'h1000;
  localparam logic [AW-1:0] A1 = 64'h20;
  localparam logic [DW-1:0] W0 = 32'hA5A5A5A5;
  localparam logic [DW-1:0] W1 = 32'h12345678;
  localparam logic [DW-1:0] DB = 32'hDEADBEEF;
  localparam logic [DW-1:0] CF = 32'hCAFEF00D;

  // Random-phase model state
  bit            busy;
  bit            pend[2];
  logic [1:0]    p_op[2], d_op[2];
  logic [AW-1:0] p_addr[2];
  logic [DW-1:0] p_wd[2];
  logic [DW-1:0] e_r[2];
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, last_beat;
  logic [1:0]    w_op, exp_op;
  int            issue_k, td_k, free_k, win, last_win, sel, n, exp_w;

  initial begin
    rst = 1'b1; rq0_op = 2'b00; rq1_op = 2'b00;
    rq0_addr = A0; rq0_wdata = W0; rq1_addr = A1; rq1_wdata = W1;
    mem_rdata = '0; mem_ready = 1'b1; mem_tx_done = 1'b0; mem_rd_valid = 1'b0;

    // Inputs of row i are sampled at the next edge; expectations are the outputs after it
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0,  0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0,  0, A0, W0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0,  0, A0, W0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0,  0, A0, W0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, DB, 0, 1, 0, 1, 0, DB, 0, A0, W0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, DB, 0, A0, W0));
    vecs.push_back(mk(0, 0, 2, 1, 0, 0, 0,  2, 0, 1, 0, 0, DB, 0, A1, W1));
    vecs.push_back(mk(0, 0, 2, 1, 0, 0, 0,  0, 0, 1, 0, 0, DB, 0, A1, W1));
    vecs.push_back(mk(0, 0, 2, 1, 1, 0, 0,  0, 0, 1, 0, 1, DB, 0, A1, W1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, DB, 0, A1, W1));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DB, 0, A1, W1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DB, 0, A1, W1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, DB, 0, A0, W0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, DB, 0, A0, W0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, CF, 0, 1, 0, 1, 0, CF, 0, A0, W0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, CF, 0, A0, W0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; rq0_op = vecs[i].op0; rq1_op = vecs[i].op1;
      mem_ready = vecs[i].rdy; mem_tx_done = vecs[i].txd;
      mem_rd_valid = vecs[i].rdv; mem_rdata = vecs[i].rdat;
      step();
      chk($sformatf("vec%0d_mem_op", i), 64'(mem_op), 64'(vecs[i].e_op));
      chk($sformatf("vec%0d_grant0", i), 64'(rq0_grant), 64'(vecs[i].e_g0));
      chk($sformatf("vec%0d_grant1", i), 64'(rq1_grant), 64'(vecs[i].e_g1));
      chk($sformatf("vec%0d_done0", i), 64'(rq0_done), 64'(vecs[i].e_d0));
      chk($sformatf("vec%0d_done1", i), 64'(rq1_done), 64'(vecs[i].e_d1));
      chk($sformatf("vec%0d_rdata0", i), 64'(rq0_rdata), 64'(vecs[i].e_r0));
      chk($sformatf("vec%0d_rdata1", i), 64'(rq1_rdata), 64'(vecs[i].e_r1));
      chk($sformatf("vec%0d_addr", i), mem_address, vecs[i].e_addr);
      chk($sformatf("vec%0d_wdata", i), 64'(mem_wdata), 64'(vecs[i].e_wd));
    end
    mem_tx_done = 1'b0; mem_rd_valid = 1'b0;

    // Tie after reset: both held at read for four transactions
    do_reset();
    rq0_op = 2'b01; rq1_op = 2'b01;
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_FIXED_PRI_EN
      exp_w = 0;
`else
      exp_w = t % 2;
`endif
      wait_op(n);
      chk($sformatf("tie%0d_gap", t), 64'(n), (t == 0) ? 64'd1 : 64'd2);
      chk($sformatf("tie%0d_op", t), 64'(mem_op), 64'd1);
      chk($sformatf("tie%0d_grant0", t), 64'(rq0_grant), 64'(exp_w == 0));
      chk($sformatf("tie%0d_grant1", t), 64'(rq1_grant), 64'(exp_w == 1));
      step();
      mem_tx_done = 1'b1; mem_rd_valid = 1'b1; mem_rdata = 32'h100 + 32'(t);
      step();
      mem_tx_done = 1'b0; mem_rd_valid = 1'b0;
      chk($sformatf("tie%0d_done0", t), 64'(rq0_done), 64'(exp_w == 0));
      chk($sformatf("tie%0d_done1", t), 64'(rq1_done), 64'(exp_w == 1));
      chk($sformatf("tie%0d_rdata", t), 64'((exp_w == 0) ? rq0_rdata : rq1_rdata), 64'(32'h100 + 32'(t)));
    end
    rq0_op = 2'b00; rq1_op = 2'b00;
    step();

    // Reset during WAIT, then a pending rq1 write is served
    rq0_op = 2'b01;
    wait_op(n);
    chk("rstmid_issue", 64'(mem_op), 64'd1);
    step();
    rst = 1'b1; rq0_op = 2'b00; rq1_op = 2'b10;
    step();
    chk("rstmid_mem_op", 64'(mem_op), 64'd0);
    chk("rstmid_grants", 64'({rq1_grant, rq0_grant}), 64'd0);
    chk("rstmid_dones", 64'({rq1_done, rq0_done}), 64'd0);
    chk("rstmid_rdata0", 64'(rq0_rdata), 64'd0);
    chk("rstmid_rdata1", 64'(rq1_rdata), 64'd0);
    chk("rstmid_addr", mem_address, 64'd0);
    chk("rstmid_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;
    wait_op(n);
    chk("rstmid_after_lat", 64'(n), 64'd1);
    chk("rstmid_after_op", 64'(mem_op), 64'd2);
    chk("rstmid_after_addr", mem_address, A1);
    chk("rstmid_after_wdata", 64'(mem_wdata), 64'(W1));
    chk("rstmid_after_grant1", 64'(rq1_grant), 64'd1);
    step();
    mem_tx_done = 1'b1;
    step();
    mem_tx_done = 1'b0;
    chk("rstmid_after_done1", 64'(rq1_done), 64'd1);
    rq1_op = 2'b00;
    step();

    // Randomized traffic against a transaction timeline model
    do_reset();
    busy = 1'b0; free_k = 0; last_win = 1; win = 0; issue_k = 0; td_k = 0;
    e_r[0] = '0; e_r[1] = '0; e_addr = '0; e_wd = '0; last_beat = '0; w_op = 2'b00;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; p_op[r] = 2'b00; d_op[r] = 2'b00; p_addr[r] = '0; p_wd[r] = '0;
    end
    for (int k = 1; k <= 2500; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          sel = int'($urandom_range(0, 5));
          p_addr[r] = {$urandom, $urandom};
          p_wd[r] = $urandom;
          if (sel < 2) begin
            pend[r] = 1'b1;
            p_op[r] = (sel == 0) ? 2'b01 : 2'b10;
          end else begin
            d_op[r] = (sel == 2) ? 2'b11 : 2'b00;
          end
        end
        if (pend[r]) d_op[r] = p_op[r];
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_tx_done = 1'b0; mem_rd_valid = 1'b0; mem_rdata = $urandom;
      if (busy && k >= issue_k + 2 && k <= td_k && w_op == 2'b01) begin
        if (k == td_k || $urandom_range(0, 1) == 1) begin
          mem_rd_valid = 1'b1;
          last_beat = mem_rdata;
        end
      end
      if (busy && k == td_k) mem_tx_done = 1'b1;
      if (!busy && k >= free_k && mem_ready && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_FIXED_PRI_EN
          win = 0;
`else
          win = (last_win == 0) ? 1 : 0;
`endif
        end else begin
          win = pend[1] ? 1 : 0;
        end
        busy = 1'b1; issue_k = k; td_k = k + 2 + int'($urandom_range(0, 3));
        w_op = p_op[win]; e_addr = p_addr[win]; e_wd = p_wd[win];
      end
      rq0_op = d_op[0]; rq0_addr = p_addr[0]; rq0_wdata = p_wd[0];
      rq1_op = d_op[1]; rq1_addr = p_addr[1]; rq1_wdata = p_wd[1];
      step();
      exp_op = (busy && k == issue_k) ? w_op : 2'b00;
      if (busy && k == td_k) e_r[win] = (w_op == 2'b10) ? '0 : last_beat;
      chk($sformatf("rnd%0d_mem_op", k), 64'(mem_op), 64'(exp_op));
      chk($sformatf("rnd%0d_grant0", k), 64'(rq0_grant), 64'(busy && win == 0));
      chk($sformatf("rnd%0d_grant1", k), 64'(rq1_grant), 64'(busy && win == 1));
      chk($sformatf("rnd%0d_done0", k), 64'(rq0_done), 64'(busy && k == td_k && win == 0));
      chk($sformatf("rnd%0d_done1", k), 64'(rq1_done), 64'(busy && k == td_k && win == 1));
      chk($sformatf("rnd%0d_rdata0", k), 64'(rq0_rdata), 64'(e_r[0]));
      chk($sformatf("rnd%0d_rdata1", k), 64'(rq1_rdata), 64'(e_r[1]));
      chk($sformatf("rnd%0d_addr", k), mem_address, e_addr);
      chk($sformatf("rnd%0d_wdata", k), 64'(mem_wdata), 64'(e_wd));
      if (busy && k == td_k) begin
        busy = 1'b0;
        last_win = win;
        pend[win] = 1'b0;
        free_k = k + 2;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single word-side port of mem_ctrl between two requesters: requester 0 (instruction fetch) and requester 1 (data load/store) of the cpu.
- Arbitrates between them, latches the winner's op/address/write data, drives mem_ctrl for exactly one transaction, then returns read data and a done pulse to the winner.
- Sits between cpu and mem_ctrl; mem_ctrl's host/cache-line side is untouched.

Parameters:
ADDR_BITCOUNT, 64, byte address width on all address ports
WORD_SIZE, 32, data word width on all data ports

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
rq0_op  in  2  requester 0 op: 00 idle, 01 read, 10 write, 11 reserved (treated as idle)
rq0_addr  in  ADDR_BITCOUNT  requester 0 address
rq0_wdata  in  WORD_SIZE  requester 0 write data
rq0_grant  out  1  requester 0 owns the memory port
rq0_rdata  out  WORD_SIZE  read data to requester 0
rq0_done  out  1  one-cycle completion pulse to requester 0
rq1_op, rq1_addr, rq1_wdata, rq1_grant, rq1_rdata, rq1_done  same as rq0_*, for requester 1
mem_op  out  2  op to mem_ctrl, same encoding
mem_address  out  ADDR_BITCOUNT  address to mem_ctrl
mem_wdata  out  WORD_SIZE  write data to mem_ctrl
mem_rdata  in  WORD_SIZE  read data from mem_ctrl
mem_ready  in  1  mem_ctrl can accept an op
mem_tx_done  in  1  mem_ctrl transaction complete, one-cycle pulse
mem_rd_valid  in  1  mem_rdata valid this cycle

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1, so requester 0 wins the first tie.
- Reset mid-transaction: return to IDLE next edge and drop mem_op/grant/done. The in-flight transaction is abandoned; mem_ctrl is reset by the same system reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If mem_ready=1 and at least one requester has op 01 or 10, choose the winner and go to ISSUE.
  - At that edge, latch winner id, op, addr and wdata into holding registers.
  - If mem_ready=0, stay in IDLE and latch nothing.
- Winner selection:
  - Only one requester valid: it wins.
  - Both valid: the requester with id != last_grant wins (round-robin).
- ISSUE:
  - Drive mem_op = latched op for exactly one cycle, plus mem_address and mem_wdata.
  - Assert the winner's grant; go to WAIT.
- WAIT:
  - mem_op = 00; mem_address and mem_wdata stay held; grant stays asserted.
  - On mem_rd_valid=1, capture mem_rdata into the read register. A later beat overwrites an earlier one.
  - On mem_tx_done=1, go to RESP. If mem_rd_valid and mem_tx_done arrive in the same cycle, the capture still happens.
  - No timeout.
- RESP:
  - Assert the winner's done for one cycle; its rdata holds the captured word (0 for writes).
  - Set last_grant = winner; go to IDLE.
- Grant: asserted in ISSUE, WAIT and RESP for the winner only. Never asserted for both requesters.
- rdata: holds its value until the next RESP for that requester.
- Requester contract:
  - Hold op, addr and wdata stable from request until done.
  - Clear op at the clock edge where done=1, so IDLE sees the new value.
- Latency: request seen in IDLE at cycle N → mem_op pulse at N+1 → done one cycle after mem_tx_done. Minimum 4 cycles request-to-done when mem_tx_done arrives on the first WAIT cycle.
- Back-to-back: both requesters held continuously alternate 0,1,0,1. One idle cycle between transactions.

Optional Feature:
MEM_ARB_FIXED_PRI_EN
- Defined: requester 0 always wins when both are valid; last_grant is still updated but ignored.
- Undefined: round-robin as above.

Test Plan:
- Single read: reset, rq0_op=01, rq0_addr=0x1000; mem returns rd_valid+tx_done with 0xDEADBEEF on the 2nd WAIT cycle → mem_op=01 for exactly one cycle with mem_address=0x1000, rq0_done one-cycle pulse, rq0_rdata=0xDEADBEEF, rq1_grant=0 throughout.
- Write: rq1_op=10, rq1_addr=0x20, rq1_wdata=0x12345678 → mem_op=10 with mem_wdata=0x12345678; rq1_done pulses; rq1_rdata=0.
- Tie after reset: both requesters held at 01 for 4 transactions → grant order 0,1,0,1; with MEM_ARB_FIXED_PRI_EN → 0,0,0,0.
- Stall: mem_ready=0 for 5 cycles while rq0_op=01 → FSM stays IDLE, mem_op=00, no grant; ISSUE occurs the cycle after mem_ready rises.
- Reset mid-op: assert rst during WAIT → next cycle all outputs 0, state IDLE; after release, a pending rq1 request is served normally.
- Reserved op: rq0_op=11 held for 10 cycles → no grant, mem_op stays 00.
